// File: rtl/dino_jump_renderer.sv
// Pixel-colour stage behind the VGA timing generator: per-frame T-rex jump physics
// and registered 12-bit RGB for the current pixel.
module dino_jump_renderer #(
  parameter int X_POS    = 64,
  parameter int DINO_W   = 20,
  parameter int DINO_H   = 24,
  parameter int GROUND_Y = 400,
  parameter int JUMP_V   = 12,
  parameter int GRAVITY  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pixel_clk,
  input  logic        active,
  input  logic        animate,
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  input  logic        jump_btn,
  output logic [11:0] rgb,
  output logic        airborne,
  output logic [7:0]  dino_h
);

  typedef enum logic [1:0] {GROUND, RISE, FALL} state_t;

  localparam logic [10:0] X_LO    = 11'(X_POS);
  localparam logic [10:0] X_HI    = 11'(X_POS + DINO_W - 1);
  localparam logic [10:0] TOP_0   = 11'(GROUND_Y - DINO_H);
  localparam logic [10:0] BOX_H   = 11'(DINO_H - 1);
  localparam logic [10:0] GND_0   = 11'(GROUND_Y);
  localparam logic [10:0] GND_1   = 11'(GROUND_Y + 1);
  localparam logic [3:0]  JV      = 4'(JUMP_V);
  localparam logic [3:0]  GV      = 4'(GRAVITY);

  state_t      state;
  logic [3:0]  vel;
  logic        pending;
  logic        btn_q;

  logic        tick;
  logic        btn_edge;
  logic [4:0]  fall_sum;
  logic [3:0]  fall_v;
  logic [10:0] top;
  logic [10:0] xe;
  logic [10:0] ye;
  logic        in_dino;
  logic [11:0] pix_rgb;

  assign tick     = animate & pixel_clk;
  assign btn_edge = jump_btn & ~btn_q;
  assign airborne = (state != GROUND);

  // Falling speed saturates at the launch speed so the descent mirrors the ascent.
  assign fall_sum = {1'b0, vel} + {1'b0, GV};
  assign fall_v   = (fall_sum > {1'b0, JV}) ? JV : fall_sum[3:0];

  assign top = TOP_0 - {3'b000, dino_h};
  assign xe  = {1'b0, x};
  assign ye  = {2'b00, y};
  assign in_dino = (xe >= X_LO) && (xe <= X_HI) && (ye >= top) && (ye <= top + BOX_H);

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    pix_rgb = 12'hFFF;
    if (!active)
      pix_rgb = 12'h000;
    else if (in_dino)
      pix_rgb = 12'h555;
    else if (ye == GND_0 || ye == GND_1)
      pix_rgb = 12'h333;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= GROUND;
      dino_h  <= 8'd0;
      vel     <= 4'd0;
      pending <= 1'b0;
      btn_q   <= 1'b0;
      rgb     <= 12'h000;
    end else begin
      btn_q <= jump_btn;
      if (pixel_clk)
        rgb <= pix_rgb;

      case (state)
        GROUND: begin
          if (tick && (pending || btn_edge)) begin
            state   <= RISE;
            vel     <= JV;
            pending <= 1'b0;
          end else if (btn_edge) begin
            pending <= 1'b1;
          end
        end
        RISE: begin
          if (tick) begin
            dino_h <= dino_h + {4'd0, vel};
            if (vel <= GV) begin
              state <= FALL;
              vel   <= 4'd0;
            end else begin
              vel <= vel - GV;
            end
          end
        end
        FALL: begin
          if (tick) begin
            if (dino_h <= {4'd0, fall_v}) begin
              state  <= GROUND;
              dino_h <= 8'd0;
              vel    <= 4'd0;
            end else begin
              dino_h <= dino_h - {4'd0, fall_v};
              vel    <= fall_v;
            end
          end
        end
        default: state <= GROUND;
      endcase
    end
  end

endmodule

// File: tb/tb_dino_jump_renderer.sv
// Randomized bench for dino_jump_renderer against a closed-form jump/pixel model.
module tb_dino_jump_renderer;

  localparam int JV = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        pixel_clk;
  logic        active;
  logic        animate;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        jump_btn;
  logic [11:0] rgb;
  logic        airborne;
  logic [7:0]  dino_h;

  dino_jump_renderer dut (
    .clk(clk), .rst(rst), .pixel_clk(pixel_clk), .active(active), .animate(animate),
    .x(x), .y(y), .jump_btn(jump_btn), .rgb(rgb), .airborne(airborne), .dino_h(dino_h)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Model: air time counted in ticks since launch; height from kinematics (gravity 1).
  bit          m_air;
  int          m_t;
  bit          m_pend;
  bit          m_btn_q;
  logic [11:0] m_rgb;

  function automatic int height(input bit air, input int t);
    int m;
    if (!air) return 0;
    if (t <= JV) return JV * t - t * (t - 1) / 2;
    m = t - JV;
    return JV * (JV + 1) / 2 - m * (m + 1) / 2;
  endfunction

  function automatic logic [11:0] pix(input int px, input int py, input bit act, input int h);
    int top;
    top = 400 - 24 - h;
    if (!act) return 12'h000;
    if (px >= 64 && px <= 83 && py >= top && py <= top + 23) return 12'h555;
    if (py == 400 || py == 401) return 12'h333;
    return 12'hFFF;
  endfunction

  task automatic model_reset();
    m_air = 0; m_t = 0; m_pend = 0; m_btn_q = 0; m_rgb = 12'h000;
  endtask

  // Apply one clock with the current inputs, advance the model, then compare.
  task automatic step(input string tag);
    bit tick, edg;
    tick = animate & pixel_clk;
    edg  = jump_btn & ~m_btn_q;
    if (pixel_clk) m_rgb = pix(int'(x), int'(y), active, height(m_air, m_t));
    if (!m_air) begin
      if (tick && (m_pend || edg)) begin
        m_air = 1; m_t = 0; m_pend = 0;
      end else if (edg) m_pend = 1;
    end else if (tick) begin
      m_t++;
      if (m_t == 2 * JV) begin m_air = 0; m_t = 0; end
    end
    m_btn_q = jump_btn;
    @(posedge clk); #1;
    check({tag, ".rgb"}, rgb, m_rgb);
    check({tag, ".air"}, {11'd0, airborne}, {11'd0, m_air});
    check({tag, ".h"}, {4'd0, dino_h}, 12'(height(m_air, m_t)));
  endtask

  task automatic show(input int px, input int py, input bit act, input logic [11:0] exp, input string tag);
    x = 10'(px); y = 9'(py); active = act; pixel_clk = 1; animate = 0;
    step(tag);
    check({tag, ".const"}, rgb, exp);
    pixel_clk = 0;
  endtask

  task automatic do_tick(input string tag);
    animate = 1; pixel_clk = 1; active = 0;
    step(tag);
    animate = 0; pixel_clk = 0;
  endtask

  int exp_h [24] = '{12, 23, 33, 42, 50, 57, 63, 68, 72, 75, 77, 78,
                     77, 75, 72, 68, 63, 57, 50, 42, 33, 23, 12, 0};

  initial begin
    rst = 0; pixel_clk = 0; active = 1; animate = 0; x = 0; y = 0; jump_btn = 0;
    model_reset();

    // Reset held with pixel enables toggling.
    for (int i = 0; i < 4; i++) begin
      pixel_clk = ~pixel_clk; x = 10'(i * 30); y = 9'(i * 100);
      @(posedge clk); #1;
      check("rst.rgb", rgb, 12'h000);
      check("rst.air", {11'd0, airborne}, 12'd0);
      check("rst.h", {4'd0, dino_h}, 12'd0);
    end
    rst = 1; pixel_clk = 0;
    @(posedge clk); #1;

    // Static frame.
    show(0, 0, 1, 12'hFFF, "px0_0");
    show(64, 376, 1, 12'h555, "px64_376");
    show(83, 399, 1, 12'h555, "px83_399");
    show(84, 399, 1, 12'hFFF, "px84_399");
    show(10, 400, 1, 12'h333, "px10_400");
    show(10, 402, 1, 12'hFFF, "px10_402");
    show(70, 390, 0, 12'h000, "blank");
    step("hold");
    check("hold.const", rgb, 12'h000);

    // Full jump: press without tick, launch on next tick, then 24 physics ticks.
    jump_btn = 1; step("press");
    check("press.h", {4'd0, dino_h}, 12'd0);
    jump_btn = 0;
    do_tick("launch");
    check("launch.air", {11'd0, airborne}, 12'd1);
    for (int k = 0; k < 24; k++) begin
      if (k == 4) jump_btn = 1;   // press while airborne, held through landing
      do_tick("jump");
      check("jump.seq", {4'd0, dino_h}, 12'(exp_h[k]));
    end
    check("landed.air", {11'd0, airborne}, 12'd0);
    for (int k = 0; k < 3; k++) do_tick("held");
    check("held.air", {11'd0, airborne}, 12'd0);
    jump_btn = 0; step("release");
    jump_btn = 1; step("repress");
    do_tick("relaunch");
    check("relaunch.air", {11'd0, airborne}, 12'd1);
    jump_btn = 0;
    for (int k = 0; k < 24; k++) do_tick("fly2");

    // Edge and tick in the same clock.
    jump_btn = 1; do_tick("same");
    check("same.air", {11'd0, airborne}, 12'd1);
    jump_btn = 0;
    do_tick("same1");
    check("same1.h", {4'd0, dino_h}, 12'd12);

    // Climb to 50, then reset mid-jump.
    for (int k = 0; k < 30 && dino_h != 8'd50; k++) do_tick("climb");
    check("reach50", {4'd0, dino_h}, 12'd50);
    rst = 0; #1;
    check("midrst.h", {4'd0, dino_h}, 12'd0);
    check("midrst.air", {11'd0, airborne}, 12'd0);
    check("midrst.rgb", rgb, 12'h000);
    @(posedge clk); #1;
    rst = 1;
    model_reset();
    do_tick("postrst");
    check("postrst.air", {11'd0, airborne}, 12'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int h;
      h = height(m_air, m_t);
      pixel_clk = 1'($urandom_range(0, 1));
      active    = ($urandom_range(0, 7) != 0);
      animate   = (i % 40 == 39);
      if (animate) pixel_clk = 1;
      case ($urandom_range(0, 3))
        0: x = 10'($urandom_range(62, 66));
        1: x = 10'($urandom_range(81, 86));
        default: x = 10'($urandom_range(0, 639));
      endcase
      case ($urandom_range(0, 3))
        0: y = 9'(375 - h + int'($urandom_range(0, 2)));
        1: y = 9'($urandom_range(397, 403));
        2: y = 9'(398 - h + int'($urandom_range(0, 2)));
        default: y = 9'($urandom_range(0, 479));
      endcase
      if ($urandom_range(0, 15) == 0) jump_btn = ~jump_btn;
      step("rand");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
